sync_frame_tx: RTL and testbench

Serial frame transmitter that is the sending end of the 1011 sync-detect link. On each accepted `start`, it emits a one-bit-per-clock frame: the 4-bit sync header `1011`, then a `DATA_W`-bit payload sent MSB-first. A zero-bit-stuffing rule guarantees that `1011` never appears anywhere in the serial stream except as the header. The block drives the line that an overlapping Moore `1011` detector samples, so that detector fires exactly once per frame, on the header.

---
 rtl/sync_frame_tx.sv | 133 +++++++++++++
 tb/tb_sync_frame_tx.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_tx.sv
// Serial frame transmitter: 1011 sync header followed by a MSB-first payload,
// with zero-bit stuffing so that 1011 never appears outside the header.
module sync_frame_tx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              out,
    output logic              busy,
    output logic              done,
    output logic              stuff
);
    localparam int               CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SYNC, DATA, DONE} state_t;

    state_t            state, state_nxt;
    logic [1:0]        hdr_idx, hdr_idx_nxt;
    logic [CNT_W-1:0]  rem, rem_nxt;
    logic [2:0]        hist, hist_nxt;
    logic [DATA_W-1:0] shreg;
    logic              out_nxt, busy_nxt, done_nxt, stuff_nxt;
    logic              accept, consume, emit;

    function automatic logic hdr_bit(input logic [1:0] idx);
        logic b;
        case (idx)
            2'd0:    b = 1'b1;
            2'd1:    b = 1'b0;
            default: b = 1'b1;
        endcase
        return b;
    endfunction

    assign accept = (state == IDLE) && start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            hdr_idx <= 2'd0;
            rem     <= '0;
            hist    <= 3'b000;
            out     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            stuff   <= 1'b0;
        end else begin
            state   <= state_nxt;
            hdr_idx <= hdr_idx_nxt;
            rem     <= rem_nxt;
            hist    <= hist_nxt;
            out     <= out_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            stuff   <= stuff_nxt;
        end
    end

    // Payload shifter carries data only; it is always reloaded on acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            shreg <= data_in;
        end else if (consume) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SYNC;
            SYNC:    if (hdr_idx == 2'd3) state_nxt = DATA;
            DATA:    if (rem == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next-cycle line values; hist holds the last three bits put on the line.
    always_comb begin
        out_nxt     = 1'b0;
        busy_nxt    = 1'b0;
        done_nxt    = 1'b0;
        stuff_nxt   = 1'b0;
        consume     = 1'b0;
        emit        = 1'b0;
        hdr_idx_nxt = hdr_idx;
        rem_nxt     = rem;
        case (state)
            IDLE: begin
                if (start) begin
                    out_nxt     = hdr_bit(2'd0);
                    busy_nxt    = 1'b1;
                    hdr_idx_nxt = 2'd0;
                    rem_nxt     = CNT_FULL;
                end
            end
            SYNC: begin
                busy_nxt = 1'b1;
                if (hdr_idx != 2'd3) begin
                    hdr_idx_nxt = hdr_idx + 2'd1;
                    out_nxt     = hdr_bit(hdr_idx_nxt);
                end else begin
                    emit = 1'b1;
                end
            end
            DATA: begin
                busy_nxt = 1'b1;
                if (rem == '0) begin
                    done_nxt = 1'b1;
                end else begin
                    emit = 1'b1;
                end
            end
            default: ;
        endcase
        if (emit) begin
            if (hist == 3'b101) begin
                stuff_nxt = 1'b1;
            end else begin
                out_nxt = shreg[DATA_W-1];
                consume = 1'b1;
                rem_nxt = rem - CNT_ONE;
            end
        end
        hist_nxt = accept ? {2'b00, out_nxt} : {hist[1:0], out_nxt};
    end

endmodule

// File: tb/tb_sync_frame_tx.sv
// Bench for sync_frame_tx: per-cycle scoreboard on two instances (8- and 5-bit
// payloads) with a reference 1011 detector folded into every cycle record.
module tb_sync_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start5;
    logic [7:0] din8;
    logic [4:0] din5;
    logic       out8, busy8, done8, stuff8;
    logic       out5, busy5, done5, stuff5;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic out;
        logic busy;
        logic done;
        logic stuff;
        logic det;
    } rec_t;

    typedef struct {
        logic [7:0]  data;
        int          n;
        logic [17:0] bits;
        logic [17:0] smask;
    } vec_t;

    rec_t sbq[2][$];
    vec_t tbl[6];
    logic [3:0] win8 = 4'b0000;
    logic [3:0] win5 = 4'b0000;

    sync_frame_tx #(.DATA_W(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .data_in(din8),
        .out(out8), .busy(busy8), .done(done8), .stuff(stuff8)
    );

    sync_frame_tx #(.DATA_W(5)) u5 (
        .clk(clk), .rst(rst), .start(start5), .data_in(din5),
        .out(out5), .busy(busy5), .done(done5), .stuff(stuff5)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic void push_header(input int k);
        logic [3:0] hdr;
        hdr = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            sbq[k].push_back('{out: hdr[i], busy: 1'b1, done: 1'b0, stuff: 1'b0, det: (i == 0)});
        end
    endfunction

    function automatic void push_done(input int k);
        sbq[k].push_back('{out: 1'b0, busy: 1'b1, done: 1'b1, stuff: 1'b0, det: 1'b0});
    endfunction

    function automatic void push_table(input int k, input vec_t v);
        push_header(k);
        for (int i = v.n - 1; i >= 0; i--) begin
            sbq[k].push_back('{out: v.bits[i], busy: 1'b1, done: 1'b0, stuff: v.smask[i], det: 1'b0});
        end
        push_done(k);
    endfunction

    // Bit-level model of the stuffing rule applied to the serial stream.
    function automatic void push_model(input int k, input logic [7:0] d, input int w);
        logic [2:0] h;
        logic       b;
        int         rem;
        push_header(k);
        h   = 3'b011;
        rem = w;
        while (rem > 0) begin
            if (h == 3'b101) begin
                b = 1'b0;
                sbq[k].push_back('{out: 1'b0, busy: 1'b1, done: 1'b0, stuff: 1'b1, det: 1'b0});
            end else begin
                b = d[rem-1];
                sbq[k].push_back('{out: b, busy: 1'b1, done: 1'b0, stuff: 1'b0, det: 1'b0});
                rem--;
            end
            h = {h[1:0], b};
        end
        push_done(k);
    endfunction

    always @(negedge clk) begin
        rec_t a, e;
        win8 = {win8[2:0], out8};
        a = '{out: out8, busy: busy8, done: done8, stuff: stuff8, det: (win8 == 4'b1011)};
        if (sbq[0].size() > 0) e = sbq[0].pop_front();
        else e = '0;
        chk("w8_cycle{out,busy,done,stuff,det}", 32'(a), 32'(e));
    end

    always @(negedge clk) begin
        rec_t a, e;
        win5 = {win5[2:0], out5};
        a = '{out: out5, busy: busy5, done: done5, stuff: stuff5, det: (win5 == 4'b1011)};
        if (sbq[1].size() > 0) e = sbq[1].pop_front();
        else e = '0;
        chk("w5_cycle{out,busy,done,stuff,det}", 32'(a), 32'(e));
    end

    // Returns right after the acceptance edge with start still high.
    task automatic accept(input int k, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (k == 0) begin
            start8 = 1'b1;
            din8   = d;
        end else begin
            start5 = 1'b1;
            din5   = d[4:0];
        end
        @(posedge clk);
    endtask

    task automatic drop(input int k);
        #1;
        if (k == 0) start8 = 1'b0;
        else start5 = 1'b0;
    endtask

    task automatic drain(input int k);
        int n;
        n = 0;
        while (sbq[k].size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq[k].size() > 0) begin
            chk("drain_timeout_queue_left", 32'(sbq[k].size()), 32'd0);
            sbq[k].delete();
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 0xBF gives five stuffs (none after the last bit); 0x7F reaches DATA_W-2.
        tbl[0] = '{8'h00,  8, 18'b00000000,       18'b0};
        tbl[1] = '{8'hB4, 10, 18'b1010100100,     18'b0001010000};
        tbl[2] = '{8'h7F, 14, 18'b01010101010101, 18'b00101010101010};
        tbl[3] = '{8'hBF, 13, 18'b1010101010101,  18'b0001010101010};
        tbl[4] = '{8'hFF,  8, 18'b11111111,       18'b0};
        tbl[5] = '{8'hAA, 10, 18'b1010010100,     18'b0001000010};

        rst    = 1'b1;
        start8 = 1'b0;
        start5 = 1'b0;
        din8   = '0;
        din5   = '0;
        #1 rst = 1'b0;
        #2;
        chk("reset_w8_outputs", 32'({out8, busy8, done8, stuff8}), 32'd0);
        chk("reset_w5_outputs", 32'({out5, busy5, done5, stuff5}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            accept(0, tbl[i].data);
            push_table(0, tbl[i]);
            drop(0);
            drain(0);
        end

        // start pulses during SYNC/DATA and in the DONE cycle are ignored
        accept(0, 8'hB4);
        push_table(0, tbl[1]);
        drop(0);
        repeat (2) @(posedge clk);
        #1 start8 = 1'b1;
        din8 = 8'hFF;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (11) @(posedge clk);
        #1 start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        drain(0);

        // start held high: frame, DONE, one IDLE, repeat with a 14-cycle period
        @(posedge clk);
        #1 start8 = 1'b1;
        din8 = 8'hFF;
        for (int f = 0; f < 3; f++) begin
            @(posedge clk);
            push_table(0, tbl[4]);
            sbq[0].push_back('0);
            repeat (13) @(posedge clk);
        end
        #1 start8 = 1'b0;
        drain(0);

        // reset in cycle T0+7 of an 0xAA frame, then a clean 0x00 frame
        accept(0, 8'hAA);
        push_table(0, tbl[5]);
        drop(0);
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        sbq[0].delete();
        #1;
        chk("midframe_reset_w8_outputs", 32'({out8, busy8, done8, stuff8}), 32'd0);
        chk("midframe_reset_w5_outputs", 32'({out5, busy5, done5, stuff5}), 32'd0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        accept(0, 8'h00);
        push_table(0, tbl[0]);
        drop(0);
        drain(0);

        fork
            begin
                for (int f = 0; f < 500; f++) begin
                    logic [7:0] d;
                    d = 8'($urandom_range(0, 255));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    accept(0, d);
                    push_model(0, d, 8);
                    drop(0);
                    drain(0);
                end
            end
            begin
                for (int f = 0; f < 500; f++) begin
                    logic [7:0] d;
                    d = 8'($urandom_range(0, 31));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    accept(1, d);
                    push_model(1, d, 5);
                    drop(1);
                    drain(1);
                end
            end
        join

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
